// File: rtl/move_validate.sv
// move_validate
//   Validates a proposed piece move against the board, one footprint cell per
//   cycle. When the scan ends it either commits the move into the current
//   position registers, rejects it, or signals a lock for a colliding downward
//   move.
//
//   Timing: a req sampled at edge E0 starts the scan. Footprint cells 0..15 are
//   visited in the 16 cycles after E0, one DRAIN cycle collects the last read,
//   and the single result pulse is high in the 18th cycle after E0 (the RESULT
//   state). The scan never exits early.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req, req_is_down         move request (taken only in IDLE) and its kind
//   test_pos_x/y, test_rot   proposed position / rotation
//   test_shape               4x4 footprint mask, bit r*4+c = row r, column c
//   load, spawn_x/y/rot      spawn a new piece (taken only in IDLE)
//   board_rd_en/x/y          board read request (combinational, during SCAN)
//   board_rd_data            occupancy, valid the cycle after board_rd_en
//   busy                     high in SCAN and DRAIN
//   commit, reject, lock     one-cycle result pulses (RESULT state)
//   cur_pos_x/y, cur_rot     authoritative current piece position
module move_validate #(
  parameter int BITS_X_POS = 4,
  parameter int BITS_Y_POS = 5,
  parameter int BITS_ROT   = 2,
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_is_down,
  input  logic [BITS_X_POS-1:0] test_pos_x,
  input  logic [BITS_Y_POS-1:0] test_pos_y,
  input  logic [BITS_ROT-1:0]   test_rot,
  input  logic [15:0]           test_shape,
  input  logic                  load,
  input  logic [BITS_X_POS-1:0] spawn_x,
  input  logic [BITS_Y_POS-1:0] spawn_y,
  input  logic [BITS_ROT-1:0]   spawn_rot,
  output logic                  board_rd_en,
  output logic [BITS_X_POS-1:0] board_rd_x,
  output logic [BITS_Y_POS-1:0] board_rd_y,
  input  logic                  board_rd_data,
  output logic                  busy,
  output logic                  commit,
  output logic                  reject,
  output logic                  lock,
  output logic [BITS_X_POS-1:0] cur_pos_x,
  output logic [BITS_Y_POS-1:0] cur_pos_y,
  output logic [BITS_ROT-1:0]   cur_rot
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

  // Bounds at one extra bit so that x+col / y+row never wraps back in range.
  localparam logic [BITS_X_POS:0] BOUND_X = (BITS_X_POS+1)'(BOARD_W);
  localparam logic [BITS_Y_POS:0] BOUND_Y = (BITS_Y_POS+1)'(BOARD_H);

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [BITS_X_POS-1:0] lat_x_q, lat_x_d;
  logic [BITS_Y_POS-1:0] lat_y_q, lat_y_d;
  logic [BITS_ROT-1:0]   lat_rot_q, lat_rot_d;
  logic [15:0]           lat_shape_q, lat_shape_d;
  logic                  lat_down_q, lat_down_d;
  logic                  col_q, col_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [BITS_X_POS-1:0] cur_x_q, cur_x_d;
  logic [BITS_Y_POS-1:0] cur_y_q, cur_y_d;
  logic [BITS_ROT-1:0]   cur_rot_q, cur_rot_d;
  logic                  commit_q, commit_d;
  logic                  reject_q, reject_d;
  logic                  lock_q, lock_d;

  logic [BITS_X_POS:0]   cell_x;
  logic [BITS_Y_POS:0]   cell_y;
  logic                  cell_on;
  logic                  col_acc;

  always_comb begin
    cell_x  = {1'b0, lat_x_q} + (BITS_X_POS+1)'(idx_q[1:0]);
    cell_y  = {1'b0, lat_y_q} + (BITS_Y_POS+1)'(idx_q[3:2]);
    cell_on = lat_shape_q[idx_q];
    // Fold in the data of last cycle's read, if one was issued.
    col_acc = col_q | (rd_pend_q & board_rd_data);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_x_d     = lat_x_q;
    lat_y_d     = lat_y_q;
    lat_rot_d   = lat_rot_q;
    lat_shape_d = lat_shape_q;
    lat_down_d  = lat_down_q;
    col_d       = col_q;
    rd_pend_d   = 1'b0;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_rot_d   = cur_rot_q;
    commit_d    = 1'b0;
    reject_d    = 1'b0;
    lock_d      = 1'b0;
    board_rd_en = 1'b0;
    board_rd_x  = '0;
    board_rd_y  = '0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          cur_x_d   = spawn_x;
          cur_y_d   = spawn_y;
          cur_rot_d = spawn_rot;
        end else if (req) begin
          lat_x_d     = test_pos_x;
          lat_y_d     = test_pos_y;
          lat_rot_d   = test_rot;
          lat_shape_d = test_shape;
          lat_down_d  = req_is_down;
          col_d       = 1'b0;
          idx_d       = 4'd0;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        col_d = col_acc;
        if (cell_on) begin
          if ((cell_x >= BOUND_X) || (cell_y >= BOUND_Y)) begin
            col_d = 1'b1;
          end else begin
            board_rd_en = 1'b1;
            board_rd_x  = cell_x[BITS_X_POS-1:0];
            board_rd_y  = cell_y[BITS_Y_POS-1:0];
          end
        end
        rd_pend_d = board_rd_en;
        idx_d     = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // The verdict is registered here so the pulse and the position update
        // land on the same edge.
        col_d   = col_acc;
        state_d = RESULT;
        if (!col_acc) begin
          commit_d  = 1'b1;
          cur_x_d   = lat_x_q;
          cur_y_d   = lat_y_q;
          cur_rot_d = lat_rot_q;
        end else if (lat_down_q) begin
          lock_d = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
      end

      RESULT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      lat_x_q     <= '0;
      lat_y_q     <= '0;
      lat_rot_q   <= '0;
      lat_shape_q <= '0;
      lat_down_q  <= 1'b0;
      col_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      cur_x_q     <= BITS_X_POS'(3);
      cur_y_q     <= '0;
      cur_rot_q   <= '0;
      commit_q    <= 1'b0;
      reject_q    <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_x_q     <= lat_x_d;
      lat_y_q     <= lat_y_d;
      lat_rot_q   <= lat_rot_d;
      lat_shape_q <= lat_shape_d;
      lat_down_q  <= lat_down_d;
      col_q       <= col_d;
      rd_pend_q   <= rd_pend_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_rot_q   <= cur_rot_d;
      commit_q    <= commit_d;
      reject_q    <= reject_d;
      lock_q      <= lock_d;
    end
  end

  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign commit    = commit_q;
  assign reject    = reject_q;
  assign lock      = lock_q;
  assign cur_pos_x = cur_x_q;
  assign cur_pos_y = cur_y_q;
  assign cur_rot   = cur_rot_q;

endmodule
